// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. Synchronises the serial line, detects the start
// edge, samples each bit at mid-period and presents each completed frame as a
// byte with a one-cycle done strobe, or as a one-cycle framing-error strobe.
module uart_rx #(
    parameter int BPS     = 9_600,
    parameter int CLK_FRE = 50_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic [7:0] uart_rx_data,
    output logic       uart_rx_done,
    output logic       uart_rx_ferr,
    output logic       uart_rx_busy
);

    localparam logic [31:0] BPS_CNT = 32'(CLK_FRE / BPS);
    localparam logic [31:0] HALF    = BPS_CNT / 32'd2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        rxd_d0;
    logic        rxd_d1;
    logic        rxd_d2;
    logic [1:0]  sync_cnt;
    logic        sync_ok;
    logic        fall;
    logic [31:0] clk_cnt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        at_half;
    logic        at_end;
    logic        cnt_clr;
    logic        stop_sample;

    // The edge detector is only trusted once rxd_d2 holds a real line sample,
    // so a line that is already low when reset releases does not look like a
    // start edge against the reset value of the synchroniser.
    assign sync_ok     = (sync_cnt == 2'd3);
    assign fall        = sync_ok & rxd_d2 & ~rxd_d1;
    assign at_half     = (clk_cnt == HALF);
    assign at_end      = (clk_cnt == BPS_CNT - 32'd1);
    assign cnt_clr     = (next_state != state) &&
                         ((next_state == IDLE) || (next_state == START));
    assign stop_sample = (state == STOP) && at_half;

    // Three-flop synchroniser on the asynchronous line plus its fill counter.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rxd_d0   <= 1'b1;
            rxd_d1   <= 1'b1;
            rxd_d2   <= 1'b1;
            sync_cnt <= 2'd0;
        end else begin
            rxd_d0 <= uart_rxd;
            rxd_d1 <= rxd_d0;
            rxd_d2 <= rxd_d1;
            if (!sync_ok) begin
                sync_cnt <= sync_cnt + 2'd1;
            end
        end
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; the stop bit is left at mid-period so a back-to-back
    // start edge is not missed.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (fall) begin
                    next_state = START;
                end
            end
            START: begin
                if (at_half && rxd_d1) begin
                    next_state = IDLE;
                end else if (at_end) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (at_end && (bit_cnt == 4'd7)) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (at_half) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Bit-period and bit counters, cleared whenever IDLE or START is entered.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            clk_cnt <= 32'd0;
            bit_cnt <= 4'd0;
        end else if (cnt_clr) begin
            clk_cnt <= 32'd0;
            bit_cnt <= 4'd0;
        end else if (state != IDLE) begin
            clk_cnt <= at_end ? 32'd0 : clk_cnt + 32'd1;
            if ((state == DATA) && at_end) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // Mid-bit sampling of data bits into the shift register, LSB first.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            shreg <= 8'h00;
        end else if ((state == DATA) && at_half) begin
            shreg <= {rxd_d1, shreg[7:1]};
        end
    end

    // Registered outputs: byte/done on a good stop bit, ferr on a low one.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            uart_rx_data <= 8'h00;
            uart_rx_done <= 1'b0;
            uart_rx_ferr <= 1'b0;
            uart_rx_busy <= 1'b0;
        end else begin
            uart_rx_done <= stop_sample & rxd_d1;
            uart_rx_ferr <= stop_sample & ~rxd_d1;
            uart_rx_busy <= (next_state != IDLE);
            if (stop_sample && rxd_d1) begin
                uart_rx_data <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a byte scoreboard.
module tb_uart_rx;

    localparam int CLK_FRE  = 1_000_000;
    localparam int BPS      = 100_000;
    localparam int BPS_CNT  = 10;
    localparam int HALF     = 5;
    localparam int DONE_LAT = 3 + 9 * BPS_CNT + HALF;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       uart_rxd  = 1'b1;
    logic [7:0] uart_rx_data;
    logic       uart_rx_done;
    logic       uart_rx_ferr;
    logic       uart_rx_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_done = 0;
    int n_ferr = 0;
    int last_done_cyc = -1;
    int last_ferr_cyc = -1;
    logic [7:0] exp_q[$];

    uart_rx #(
        .BPS     (BPS),
        .CLK_FRE (CLK_FRE)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .uart_rxd     (uart_rxd),
        .uart_rx_data (uart_rx_data),
        .uart_rx_done (uart_rx_done),
        .uart_rx_ferr (uart_rx_ferr),
        .uart_rx_busy (uart_rx_busy)
    );

    initial forever #5 sys_clk = ~sys_clk;

    initial forever begin
        @(posedge sys_clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: strobe exclusivity, pulse counting, scoreboard pop.
    initial forever begin
        @(negedge sys_clk);
        if (uart_rx_done || uart_rx_ferr) begin
            chk("strobe_excl", 32'(uart_rx_done & uart_rx_ferr), 32'd0);
        end
        if (uart_rx_done) begin
            n_done++;
            last_done_cyc = cyc;
            chk("sb_avail", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                chk("sb_data", 32'(uart_rx_data), 32'(exp_q.pop_front()));
            end
        end
        if (uart_rx_ferr) begin
            n_ferr++;
            last_ferr_cyc = cyc;
        end
    end

    // Drive one 10-bit frame; called #1 after a rising edge. t0 is edge 0.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int t0);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        t0 = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            uart_rxd = fr[i];
            repeat (BPS_CNT) @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t1;
        int d0;
        int f0;
        int busy_n;
        logic [7:0] lb[4];
        logic [9:0] fr;

        // Reset state
        sys_rst_n = 1'b0;
        uart_rxd  = 1'b1;
        hold(3);
        chk("rst_data", 32'(uart_rx_data), 32'h00);
        chk("rst_done", 32'(uart_rx_done), 32'd0);
        chk("rst_ferr", 32'(uart_rx_ferr), 32'd0);
        chk("rst_busy", 32'(uart_rx_busy), 32'd0);
        sys_rst_n = 1'b1;
        hold(10);

        // Single frame 0xA5
        d0 = n_done; f0 = n_ferr;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, t0);
        chk("a5_done_cnt", 32'(n_done - d0), 32'd1);
        chk("a5_done_cyc", 32'(last_done_cyc), 32'(t0 + DONE_LAT));
        chk("a5_ferr_cnt", 32'(n_ferr - f0), 32'd0);
        chk("a5_data", 32'(uart_rx_data), 32'hA5);
        chk("a5_busy", 32'(uart_rx_busy), 32'd0);

        // Frame 0x3C with a low stop bit, then break
        d0 = n_done; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, t0);
        chk("ferr_cnt", 32'(n_ferr - f0), 32'd1);
        chk("ferr_cyc", 32'(last_ferr_cyc), 32'(t0 + DONE_LAT));
        chk("ferr_no_done", 32'(n_done - d0), 32'd0);
        chk("ferr_data_kept", 32'(uart_rx_data), 32'hA5);
        hold(300);
        chk("break_ferr_cnt", 32'(n_ferr - f0), 32'd1);
        chk("break_no_done", 32'(n_done - d0), 32'd0);
        chk("break_busy", 32'(uart_rx_busy), 32'd0);
        uart_rxd = 1'b1;
        hold(20);

        // Back-to-back frames
        d0 = n_done; f0 = n_ferr;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h81);
        send_frame(8'h00, 1'b1, t0);
        send_frame(8'hFF, 1'b1, t1);
        send_frame(8'h81, 1'b1, t1);
        chk("b2b_done_cnt", 32'(n_done - d0), 32'd3);
        chk("b2b_last_cyc", 32'(last_done_cyc), 32'(t0 + 2 * 10 * BPS_CNT + DONE_LAT));
        chk("b2b_ferr_cnt", 32'(n_ferr - f0), 32'd0);
        chk("b2b_data", 32'(uart_rx_data), 32'h81);
        chk("b2b_q_empty", 32'(exp_q.size()), 32'd0);

        // Start glitch of 3 cycles
        hold(10);
        d0 = n_done; f0 = n_ferr;
        uart_rxd = 1'b0;
        hold(3);
        uart_rxd = 1'b1;
        busy_n = 0;
        repeat (30) begin
            @(negedge sys_clk);
            if (uart_rx_busy) busy_n++;
        end
        @(posedge sys_clk);
        #1;
        chk("glitch_busy_cycles", 32'(busy_n), 32'd6);
        chk("glitch_no_done", 32'(n_done - d0), 32'd0);
        chk("glitch_no_ferr", 32'(n_ferr - f0), 32'd0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, t0);
        chk("post_glitch_done", 32'(n_done - d0), 32'd1);
        chk("post_glitch_data", 32'(uart_rx_data), 32'h3C);

        // Reset during data bit 4 of 0x5A
        hold(10);
        d0 = n_done; f0 = n_ferr;
        fr = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 5; i++) begin
            uart_rxd = fr[i];
            hold(BPS_CNT);
        end
        uart_rxd = fr[5];
        hold(3);
        sys_rst_n = 1'b0;
        hold(2);
        chk("mid_rst_data", 32'(uart_rx_data), 32'h00);
        chk("mid_rst_busy", 32'(uart_rx_busy), 32'd0);
        chk("mid_rst_done", 32'(uart_rx_done), 32'd0);
        chk("mid_rst_ferr", 32'(uart_rx_ferr), 32'd0);
        sys_rst_n = 1'b1;
        uart_rxd  = 1'b1;
        hold(30);
        chk("abort_no_done", 32'(n_done - d0), 32'd0);
        chk("abort_no_ferr", 32'(n_ferr - f0), 32'd0);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, t0);
        chk("c3_done_cnt", 32'(n_done - d0), 32'd1);
        chk("c3_done_cyc", 32'(last_done_cyc), 32'(t0 + DONE_LAT));
        chk("c3_data", 32'(uart_rx_data), 32'hC3);

        // Transmitter-style stream with small random idle gaps
        d0 = n_done; f0 = n_ferr;
        lb[0] = 8'h00; lb[1] = 8'h55; lb[2] = 8'hAA; lb[3] = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(lb[i]);
            uart_rxd = 1'b1;
            hold(int'($urandom_range(0, 2)));
            send_frame(lb[i], 1'b1, t0);
        end
        hold(5);
        chk("lb_done_cnt", 32'(n_done - d0), 32'd4);
        chk("lb_ferr_cnt", 32'(n_ferr - f0), 32'd0);
        chk("lb_data", 32'(uart_rx_data), 32'hFF);
        chk("lb_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
